mux_scan_sel: RTL and testbench

//  Registered, parametrised NCH:1 selector of DW-bit channels with two modes:

---
 rtl/mux_scan_sel_if.sv | 26 ++
 rtl/mux_scan_sel.sv | 106 ++++++++++
 tb/tb_mux_scan_sel.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: channel inputs, select/mode controls and the
// registered selection outputs. The driver side uses master, the selector uses slave.
interface mux_scan_sel_if #(
    parameter int NCH  = 4,
    parameter int DW   = 2,
    parameter int SELW = 2
);
    logic [NCH*DW-1:0] x;
    logic [SELW-1:0]   sel_in;
    logic              mode;
    logic              hold;
    logic [DW-1:0]     f;
    logic [SELW-1:0]   f_sel;
    logic              f_valid;
    logic [7:0]        seg0;

    modport master (
        output x, sel_in, mode, hold,
        input  f, f_sel, f_valid, seg0
    );

    modport slave (
        input  x, sel_in, mode, hold,
        output f, f_sel, f_valid, seg0
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered NCH:1 channel selector with manual and auto-scan modes.
// Define SEG_DISPLAY_EN to drive seg0 with the selected index; otherwise seg0 is blank.
module mux_scan_sel #(
    parameter int NCH   = 4,
    parameter int DW    = 2,
    parameter int SELW  = 2,
    parameter int DWELL = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_sel_if.slave   bus
);
    localparam int CW = $clog2(DWELL) + 1;

    logic [SELW-1:0] sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q;
    logic [DW-1:0]   f_q, f_d;
    logic [SELW-1:0] fsel_q;
    logic            fvalid_q, valid_d;

    always_comb begin
        sel_d = bus.sel_in;
        cnt_d = cnt_q;
        if (bus.mode) begin
            sel_d = sel_q;
            if (!mode_q) begin
                cnt_d = '0;
            end else if (!bus.hold) begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d = '0;
                    // Out-of-range indices also land here and restart the scan at 0.
                    sel_d = (sel_q >= SELW'(NCH - 1)) ? '0 : sel_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Extra bit keeps the compare correct when NCH == 2**SELW.
    assign valid_d = ({1'b0, sel_d} < (SELW + 1)'(NCH));

    always_comb begin
        f_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_d == SELW'(k)) f_d = bus.x[k*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            f_q      <= '0;
            fsel_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mode_q   <= bus.mode;
            f_q      <= f_d;
            fsel_q   <= sel_d;
            fvalid_q <= valid_d;
        end
    end

    assign bus.f       = f_q;
    assign bus.f_sel   = fsel_q;
    assign bus.f_valid = fvalid_q;

`ifdef SEG_DISPLAY_EN
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    logic [7:0] seg_q;

    always_ff @(posedge clk) begin
        if (rst) seg_q <= 8'hFF;
        else     seg_q <= valid_d ? hex_seg(4'(sel_d)) : 8'hBF;
    end

    assign bus.seg0 = seg_q;
`else
    assign bus.seg0 = 8'hFF;
`endif
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: manual vector table, auto-scan, hold, reset
// and out-of-range sequences on NCH=4 and NCH=3 instances.
module tb_mux_scan_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux_scan_sel_if #(.NCH(4), .DW(2), .SELW(2)) bus4 ();
    mux_scan_sel_if #(.NCH(3), .DW(2), .SELW(2)) bus3 ();

    mux_scan_sel #(.NCH(4), .DW(2), .SELW(2), .DWELL(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mux_scan_sel #(.NCH(3), .DW(2), .SELW(2), .DWELL(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [7:0] x;
        logic [1:0] ef;
        logic [1:0] es;
        logic       ev;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_seg(input int s, input int nch);
`ifdef SEG_DISPLAY_EN
        int tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (s < 0) return 8'hFF;
        if (s >= nch) return 8'hBF;
        return tab[s];
`else
        return (s < nch) ? 8'hFF : 8'hFF;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input int ef, input int es, input int ev);
        check({tag, ".f"}, bus4.f, ef);
        check({tag, ".f_sel"}, bus4.f_sel, es);
        check({tag, ".f_valid"}, bus4.f_valid, ev);
    endtask

    initial begin
        bus4.x = 8'hE4; bus4.sel_in = 2'd2; bus4.mode = 1'b0; bus4.hold = 1'b0;
        bus3.x = 6'h24; bus3.sel_in = 2'd3; bus3.mode = 1'b0; bus3.hold = 1'b0;

        tbl[0] = '{1'b1, 2'd2, 8'hE4, 2'd0, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 2'd2, 8'hE4, 2'd0, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 8'hE4, 2'd2, 2'd2, 1'b1};
        tbl[3] = '{1'b0, 2'd0, 8'hE4, 2'd0, 2'd0, 1'b1};
        tbl[4] = '{1'b0, 2'd1, 8'hE4, 2'd1, 2'd1, 1'b1};
        tbl[5] = '{1'b0, 2'd2, 8'hE4, 2'd2, 2'd2, 1'b1};
        tbl[6] = '{1'b0, 2'd3, 8'hE4, 2'd3, 2'd3, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 8'h1B, 2'd3, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 2'd3, 8'h1B, 2'd0, 2'd3, 1'b1};

        // Manual-mode table: outputs reflect the inputs applied before this edge.
        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst;
            bus4.sel_in = tbl[i].sel;
            bus4.x = tbl[i].x;
            step();
            chk4($sformatf("tbl%0d", i), tbl[i].ef, tbl[i].es, tbl[i].ev);
            check($sformatf("tbl%0d.seg0", i), bus4.seg0,
                  exp_seg(tbl[i].rst ? -1 : int'(tbl[i].sel), 4));
        end

        // NCH=3 with out-of-range manual select.
        check("n3.f", bus3.f, 0);
        check("n3.f_valid", bus3.f_valid, 0);
        check("n3.f_sel", bus3.f_sel, 3);
        check("n3.seg0", bus3.seg0, exp_seg(3, 3));

        // Auto scan from sel_q=0: 8 cycles per channel, wrap after channel 3.
        bus4.x = 8'hE4; bus4.sel_in = 2'd0;
        step();
        bus4.mode = 1'b1; bus4.sel_in = 2'd3;
        for (int i = 0; i < 40; i++) begin
            step();
            chk4($sformatf("scan%0d", i), (i / 8) % 4, (i / 8) % 4, 1);
        end

        // Re-enter auto, reach cnt=5, then hold for 20 cycles.
        bus4.mode = 1'b0; bus4.sel_in = 2'd0;
        step();
        bus4.mode = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("pre_hold.f_sel", bus4.f_sel, 0);
        bus4.hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus4.x = 8'hE6;
            step();
            check($sformatf("hold%0d.f_sel", i), bus4.f_sel, 0);
            check($sformatf("hold%0d.f", i), bus4.f, (i >= 10) ? 2 : 0);
        end
        bus4.hold = 1'b0;
        bus4.x = 8'hE4;
        step(); check("rel1.f_sel", bus4.f_sel, 0);
        step(); check("rel2.f_sel", bus4.f_sel, 0);
        step(); check("rel3.f_sel", bus4.f_sel, 1);

        // Advance to channel 2, then reset mid-scan with mode held high.
        for (int i = 0; i < 8; i++) step();
        check("to2.f_sel", bus4.f_sel, 2);
        step(); step();
        rst = 1'b1;
        step();
        chk4("rstmid", 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk4($sformatf("restart%0d", i), (i < 8) ? 0 : 1, (i < 8) ? 0 : 1, 1);
        end

        // Auto -> manual: f follows sel_in at the next edge.
        bus4.mode = 1'b0; bus4.sel_in = 2'd3;
        step();
        chk4("a2m", 3, 3, 1);

        // NCH=3: out-of-range index entering auto dwells, then advances to 0.
        bus3.mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("oor%0d.f_sel", i), bus3.f_sel, (i < 8) ? 3 : 0);
            check($sformatf("oor%0d.f_valid", i), bus3.f_valid, (i < 8) ? 0 : 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
